// File: rtl/serial_compare_ctrl.sv
// Slice-serial unsigned magnitude comparator.
// Operands are captured on start and walked 3 bits per cycle, LSB slice
// first, through an eq/gt/lt cascade. The result appears a fixed NSLICE
// cycles after acceptance and is held until the consumer acknowledges it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// RUN   | one slice processed per cycle; slice_idx counts up
// DONE  | result presented on eq/gt/lt until ack
//
// WIDTH must be a multiple of 3 and at least 3.
module serial_compare_ctrl #(
  parameter  int WIDTH  = 24,
  localparam int NSLICE = WIDTH / 3,
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic             result_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [IDXW-1:0]  slice_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             ceq_q, ceq_d;
  logic             cgt_q, cgt_d;
  logic             clt_q, clt_d;

  logic [2:0] sa, sb;
  logic       last_slice;

  assign sa         = a_q[3*idx_q +: 3];
  assign sb         = b_q[3*idx_q +: 3];
  assign last_slice = (idx_q == IDXW'(NSLICE - 1));

  // State, captured operands, slice counter and cascade registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      ceq_q   <= 1'b0;
      cgt_q   <= 1'b0;
      clt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ceq_q   <= ceq_d;
      cgt_q   <= cgt_d;
      clt_q   <= clt_d;
    end
  end

  // Next-state and datapath update: capture on accept, one slice per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    ceq_d   = ceq_q;
    cgt_d   = cgt_q;
    clt_d   = clt_q;

    unique case (state_q)
      IDLE: begin
        // start beats abort here; abort has no meaning outside RUN
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          ceq_d   = 1'b1;
          cgt_d   = 1'b0;
          clt_d   = 1'b0;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          ceq_d   = 1'b0;
          cgt_d   = 1'b0;
          clt_d   = 1'b0;
        end else begin
          // a higher slice that differs overrides whatever lower slices decided
          ceq_d = (sa == sb) & ceq_q;
          cgt_d = (sa > sb) | ((sa == sb) & cgt_q);
          clt_d = (sa < sb) | ((sa == sb) & clt_q);
          if (last_slice) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d   = idx_q + IDXW'(1);
          end
        end
      end

      DONE: begin
        if (ack) begin
          if (start) begin
            // back-to-back: straight into the next compare, no idle bubble
            state_d = RUN;
            a_d     = a;
            b_d     = b;
            idx_d   = '0;
            ceq_d   = 1'b1;
            cgt_d   = 1'b0;
            clt_d   = 1'b0;
          end else begin
            state_d = IDLE;
            ceq_d   = 1'b0;
            cgt_d   = 1'b0;
            clt_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; result bits are forced low outside DONE.
  always_comb begin
    busy         = (state_q == RUN);
    result_valid = (state_q == DONE);
    eq           = result_valid & ceq_q;
    gt           = result_valid & cgt_q;
    lt           = result_valid & clt_q;
    slice_idx    = busy ? idx_q : '0;
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: table of operand pairs with hand-derived
// expected results, a queue of pending expectations, and hand-written
// sequences for abort, back-to-back, async reset and DONE hold behaviour.
module tb_serial_compare_ctrl;

  localparam int WIDTH  = 24;
  localparam int NSLICE = WIDTH / 3;
  localparam int IDXW   = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             ack;
  logic             busy;
  logic             result_valid;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [IDXW-1:0]  slice_idx;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a            (a),
    .b            (b),
    .abort        (abort),
    .ack          (ack),
    .busy         (busy),
    .result_valid (result_valid),
    .eq           (eq),
    .gt           (gt),
    .lt           (lt),
    .slice_idx    (slice_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             xeq;
    logic             xgt;
    logic             xlt;
  } vec_t;

  typedef struct {
    logic xeq;
    logic xgt;
    logic xlt;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];
  exp_t last_exp;
  int   n_checks;
  int   n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".busy"}, 32'(busy), 32'd0);
    chk({name, ".valid"}, 32'(result_valid), 32'd0);
    chk({name, ".eqgtlt"}, 32'({eq, gt, lt}), 32'd0);
    chk({name, ".idx"}, 32'(slice_idx), 32'd0);
  endtask

  // Drive start at a negedge and let the following posedge accept it.
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic xeq, input logic xgt, input logic xlt,
                        input logic with_ack, input logic with_abort, input logic push);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    ack   = with_ack;
    abort = with_abort;
    a     = va;
    b     = vb;
    e.xeq = xeq;
    e.xgt = xgt;
    e.xlt = xlt;
    if (push) sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Walk the RUN phase after acceptance, disturbing inputs that must be ignored,
  // then expect the result exactly NSLICE edges after acceptance.
  task automatic run_check(input string name);
    exp_t e;
    for (int k = 0; k < NSLICE; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        ack   = 1'b0;
        abort = 1'b0;
      end
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (k == 3) begin
        start = 1'b1;
        ack   = 1'b1;
      end
      if (k == 4) begin
        start = 1'b0;
        ack   = 1'b0;
      end
      chk({name, ".busy"}, 32'(busy), 32'd1);
      chk({name, ".idx"}, 32'(slice_idx), 32'(k));
      chk({name, ".early_valid"}, 32'(result_valid), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({name, ".valid"}, 32'(result_valid), 32'd1);
    chk({name, ".busy_done"}, 32'(busy), 32'd0);
    if (sb_q.size() == 0) begin
      chk({name, ".sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      last_exp = e;
      chk({name, ".eqgtlt"}, 32'({eq, gt, lt}), 32'({e.xeq, e.xgt, e.xlt}));
    end
  endtask

  // In DONE, start and abort without ack must change nothing.
  task automatic hold(input string name);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      abort = 1'b1;
      a     = WIDTH'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk({name, ".hold_valid"}, 32'(result_valid), 32'd1);
      chk({name, ".hold_res"}, 32'({eq, gt, lt}), 32'({last_exp.xeq, last_exp.xgt, last_exp.xlt}));
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic release_res(input string name);
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    chk_quiet({name, ".idle"});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{24'h123456, 24'h123456, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{24'h000001, 24'h000002, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{24'h000000, 24'hFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{24'h400000, 24'h3FFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{24'h0A5A5A, 24'h0A5A5B, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ack   = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // main table
    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].xeq, vecs[i].xgt, vecs[i].xlt, 1'b0, 1'b0, 1'b1);
      run_check($sformatf("vec%0d", i));
      hold($sformatf("vec%0d", i));
      release_res($sformatf("vec%0d", i));
    end

    // ack and start together in DONE: next compare starts with no bubble
    launch(24'h000001, 24'h000002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_check("b2b_first");
    launch(24'h000010, 24'h000010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_check("b2b_second");
    hold("b2b_second");
    release_res("b2b_second");

    // abort at slice 3, then a fresh compare where start and abort coincide in IDLE
    launch(24'h123456, 24'h654321, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("abort.idx", 32'(slice_idx), 32'(k));
      if (k == 3) abort = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    abort = 1'b0;
    chk_quiet("abort.next");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort.no_result", 32'(result_valid), 32'd0);
    end
    launch(24'h000007, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_check("after_abort");
    hold("after_abort");
    release_res("after_abort");

    // asynchronous reset in the middle of RUN
    launch(24'h123456, 24'h123455, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("areset.pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("areset.async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_quiet("areset.after");
    end
    launch(vecs[1].va, vecs[1].vb, vecs[1].xeq, vecs[1].xgt, vecs[1].xlt, 1'b0, 1'b0, 1'b1);
    run_check("areset.fresh");
    release_res("areset.fresh");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
